exception_unit: RTL and testbench
=================================

EXCEPTION_UNIT -- requirements
Module: exception_unit

Interface
REQ-001 SHALL have parameter EXC_VECTOR, default 64'h0000_0000_0000_00D8, handler entry address.
REQ-002 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port IRQReq  in  1  external interrupt request, level, held until IRQAck.
REQ-005 SHALL have port PC  in  64  address of instruction executing this cycle.
REQ-006 SHALL have port Exc  in  1  exception raised by main decoder this cycle.
REQ-007 SHALL have port ERet  in  1  ERET decoded this cycle.
REQ-008 SHALL have port EStatus  in  4  cause code: 0001 IRQ, 0010 invalid opcode.
REQ-009 SHALL have port SysRegSel  in  2  MRS source: 00 ELR, 01 ESR, 10 ECNT, 11 zero.
REQ-010 SHALL have port ExtIRQ  out  1  masked pending interrupt, to main decoder.
REQ-011 SHALL have port IRQAck  out  1  one-cycle acknowledge to interrupt source.
REQ-012 SHALL have port Redirect  out  1  PC mux select overriding sequential/branch PC.
REQ-013 SHALL have port ExcPC  out  64  redirect target.
REQ-014 SHALL have port Squash  out  1  suppress RegWrite/MemWrite of current instruction.
REQ-015 SHALL have port SysRegData  out  64  MRS read data.
REQ-016 SHALL have port Halted  out  1  core locked after double fault.

Function
REQ-017 SHALL implement FSM states NORMAL, HANDLER, HALT.
REQ-018 NORMAL & Exc: Redirect=1, ExcPC=EXC_VECTOR, Squash=1 combinationally; at edge ELR<=PC, ESR<=EStatus, ECNT+=1, state<=HANDLER.
REQ-019 irq_pend SHALL set on any edge with IRQReq=1, clear on edge where IRQAck=1; ExtIRQ = irq_pend & (state==NORMAL), combinational.
REQ-020 IRQAck SHALL be 1 only in a NORMAL cycle with Exc=1 and EStatus=0001.
REQ-021 IRQ plus invalid opcode same cycle: EStatus=0001 wins; ELR=PC so the opcode faults again after return.
REQ-022 ERet (either state): Redirect=1, ExcPC=ELR, Squash=0; at edge state<=NORMAL; ELR/ESR unchanged.
REQ-023 HANDLER & Exc (ERet=0): double fault; Squash=1, Redirect=0, at edge state<=HALT; ELR/ESR/ECNT unchanged.
REQ-024 HALT: Halted=1, Squash=1, Redirect=0, ExtIRQ=0, IRQAck=0; only reset exits.
REQ-025 IRQ arriving in HANDLER SHALL stay pending; earliest entry is the cycle after the ERet edge.
REQ-026 ECNT SHALL be 16-bit, saturating at 16'hFFFF.
REQ-027 SysRegData combinational from SysRegSel; ESR zero-extended to 64, ECNT zero-extended.
REQ-028 No exception: Redirect=0, Squash=0, ExcPC=0.

Reset
REQ-029 reset=0 SHALL immediately force state NORMAL, ELR=0, ESR=0, ECNT=0, irq_pend=0.
REQ-030 During reset all outputs SHALL be 0, including ExtIRQ and IRQAck.
REQ-031 Reset mid-handler SHALL discard the return context; no redirect on release.
REQ-032 First edge after reset release SHALL be able to latch IRQReq.

Structure
REQ-033 Package exc_pkg SHALL hold state enum, EStatus codes (ES_NONE 0000, ES_IRQ 0001, ES_INVOP 0010), SysRegSel codes.
REQ-034 Sub-module exc_sysregs SHALL hold ELR/ESR/ECNT with load/increment enables and read mux; FSM and IRQ latch stay in exception_unit.

Verification
REQ-035 IRQReq pulse 1 cycle at PC=0x40 in NORMAL -> next cycle ExtIRQ=1; with Exc=1,EStatus=0001: IRQAck=1, ExcPC=0xD8, then ELR=0x40, ESR=1, ECNT=1.
REQ-036 Invalid opcode at PC=0x80 -> Squash=1, ExcPC=0xD8; later ERet -> Redirect=1, ExcPC=0x80, state NORMAL.
REQ-037 IRQReq in HANDLER -> ExtIRQ stays 0; after ERet edge ExtIRQ=1 next cycle.
REQ-038 Exc in HANDLER -> HALT, Halted=1, IRQReq ignored until reset=0.
REQ-039 reset=0 mid-cycle in HANDLER -> all outputs 0 immediately, SysRegData=0 for all sel.
REQ-040 Force ECNT=0xFFFE, two exceptions -> ECNT reads 0xFFFF both times after.

Source files
------------

// File: rtl/exc_pkg.sv
// ============================================================================
// exc_pkg : shared types and encodings for the exception unit | rev 1.0
// ============================================================================
`default_nettype none

package exc_pkg;

  typedef enum logic [1:0] {
    ST_NORMAL  = 2'd0,
    ST_HANDLER = 2'd1,
    ST_HALT    = 2'd2
  } exc_state_e;

  localparam logic [3:0] ES_NONE  = 4'b0000;
  localparam logic [3:0] ES_IRQ   = 4'b0001;
  localparam logic [3:0] ES_INVOP = 4'b0010;

  localparam logic [1:0] SEL_ELR  = 2'b00;
  localparam logic [1:0] SEL_ESR  = 2'b01;
  localparam logic [1:0] SEL_ECNT = 2'b10;
  localparam logic [1:0] SEL_ZERO = 2'b11;

  localparam int ECNT_W = 16;

  function automatic logic [ECNT_W-1:0] sat_inc(input logic [ECNT_W-1:0] v);
    return (v == {ECNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/exc_sysregs.sv
// ============================================================================
// exc_sysregs : ELR/ESR/ECNT system registers with MRS read mux | rev 1.0
// ============================================================================
`default_nettype none

module exc_sysregs
  import exc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ctx_load,
  input  logic        ecnt_inc,
  input  logic [63:0] pc,
  input  logic [3:0]  estatus,
  input  logic [1:0]  sel,
  output logic [63:0] elr,
  output logic [63:0] rdata
);

  logic [63:0]       elr_q,  elr_d;
  logic [3:0]        esr_q,  esr_d;
  logic [ECNT_W-1:0] ecnt_q, ecnt_d;

  always_comb begin
    elr_d  = elr_q;
    esr_d  = esr_q;
    ecnt_d = ecnt_q;
    if (ctx_load) begin
      elr_d = pc;
      esr_d = estatus;
    end
    if (ecnt_inc) begin
      ecnt_d = sat_inc(ecnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      elr_q  <= 64'd0;
      esr_q  <= 4'd0;
      ecnt_q <= '0;
    end else begin
      elr_q  <= elr_d;
      esr_q  <= esr_d;
      ecnt_q <= ecnt_d;
    end
  end

  always_comb begin
    rdata = 64'd0;
    unique case (sel)
      SEL_ELR:  rdata = elr_q;
      SEL_ESR:  rdata = {60'd0, esr_q};
      SEL_ECNT: rdata = {{(64-ECNT_W){1'b0}}, ecnt_q};
      SEL_ZERO: rdata = 64'd0;
      default:  rdata = 64'd0;
    endcase
  end

  assign elr = elr_q;

endmodule

`default_nettype wire

// File: rtl/exception_unit.sv
// ============================================================================
// exception_unit : exception/interrupt entry, ERET return, double-fault halt
// rev 1.0
// ============================================================================
`default_nettype none

module exception_unit
  import exc_pkg::*;
#(
  parameter logic [63:0] EXC_VECTOR = 64'h0000_0000_0000_00D8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IRQReq,
  input  logic [63:0] PC,
  input  logic        Exc,
  input  logic        ERet,
  input  logic [3:0]  EStatus,
  input  logic [1:0]  SysRegSel,
  output logic        ExtIRQ,
  output logic        IRQAck,
  output logic        Redirect,
  output logic [63:0] ExcPC,
  output logic        Squash,
  output logic [63:0] SysRegData,
  output logic        Halted
);

  exc_state_e  state_q, state_d;
  logic        irq_pend_q, irq_pend_d;
  logic        ctx_load;
  logic        ecnt_inc;
  logic [63:0] elr;

  exc_sysregs u_regs (
    .clk      (clk),
    .rst_n    (reset),
    .ctx_load (ctx_load),
    .ecnt_inc (ecnt_inc),
    .pc       (PC),
    .estatus  (EStatus),
    .sel      (SysRegSel),
    .elr      (elr),
    .rdata    (SysRegData)
  );

  // Every output is qualified by reset so combinational paths stay quiet while it is held.
  always_comb begin
    state_d  = state_q;
    Redirect = 1'b0;
    ExcPC    = 64'd0;
    Squash   = 1'b0;
    IRQAck   = 1'b0;
    Halted   = 1'b0;
    ctx_load = 1'b0;
    ecnt_inc = 1'b0;
    if (reset) begin
      unique case (state_q)
        ST_NORMAL: begin
          if (ERet) begin
            Redirect = 1'b1;
            ExcPC    = elr;
          end else if (Exc) begin
            Redirect = 1'b1;
            ExcPC    = EXC_VECTOR;
            Squash   = 1'b1;
            IRQAck   = (EStatus == ES_IRQ);
            ctx_load = 1'b1;
            ecnt_inc = 1'b1;
            state_d  = ST_HANDLER;
          end
        end
        ST_HANDLER: begin
          if (ERet) begin
            Redirect = 1'b1;
            ExcPC    = elr;
            state_d  = ST_NORMAL;
          end else if (Exc) begin
            Squash  = 1'b1;
            state_d = ST_HALT;
          end
        end
        ST_HALT: begin
          Halted = 1'b1;
          Squash = 1'b1;
        end
        default: state_d = ST_NORMAL;
      endcase
    end
  end

  // Acknowledge beats a still-held request so the source can drop it next cycle.
  always_comb begin
    irq_pend_d = irq_pend_q;
    if (IRQAck) begin
      irq_pend_d = 1'b0;
    end else if (IRQReq) begin
      irq_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_NORMAL;
      irq_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      irq_pend_q <= irq_pend_d;
    end
  end

  assign ExtIRQ = reset & irq_pend_q & (state_q == ST_NORMAL);

endmodule

`default_nettype wire

// File: tb/tb_exception_unit.sv
// ============================================================================
// tb_exception_unit : directed vector table plus reset/saturation sequences
// rev 1.0
// ============================================================================
`default_nettype none

module tb_exception_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        irq_req = 1'b0;
  logic [63:0] pc = 64'd0;
  logic        exc = 1'b0;
  logic        eret = 1'b0;
  logic [3:0]  estatus = 4'd0;
  logic [1:0]  sel = 2'd0;

  logic        ext_irq, irq_ack, redirect, squash, halted;
  logic [63:0] exc_pc, sys_data;

  int n_cmp = 0;
  int n_err = 0;

  exception_unit dut (
    .clk        (clk),
    .reset      (reset),
    .IRQReq     (irq_req),
    .PC         (pc),
    .Exc        (exc),
    .ERet       (eret),
    .EStatus    (estatus),
    .SysRegSel  (sel),
    .ExtIRQ     (ext_irq),
    .IRQAck     (irq_ack),
    .Redirect   (redirect),
    .ExcPC      (exc_pc),
    .Squash     (squash),
    .SysRegData (sys_data),
    .Halted     (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        irq;
    logic        exc;
    logic        eret;
    logic [3:0]  es;
    logic [63:0] pc;
    logic [1:0]  sel;
    logic        e_red;
    logic [63:0] e_pc;
    logic        e_sq;
    logic        e_ack;
    logic        e_ext;
    logic        e_halt;
    logic [63:0] e_sys;
  } vec_t;

  vec_t vt[16];

  function automatic vec_t mk(input logic irq, input logic ex, input logic er,
                              input logic [3:0] es, input logic [63:0] p,
                              input logic [1:0] s, input logic red,
                              input logic [63:0] epc, input logic sq,
                              input logic ack, input logic ext,
                              input logic hlt, input logic [63:0] sys);
    vec_t v;
    v.irq = irq; v.exc = ex; v.eret = er; v.es = es; v.pc = p; v.sel = s;
    v.e_red = red; v.e_pc = epc; v.e_sq = sq; v.e_ack = ack;
    v.e_ext = ext; v.e_halt = hlt; v.e_sys = sys;
    return v;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic red, input logic [63:0] epc,
                            input logic sq, input logic ack, input logic ext,
                            input logic hlt);
    check({tag, ".Redirect"}, {63'd0, redirect}, {63'd0, red});
    check({tag, ".ExcPC"},    exc_pc, epc);
    check({tag, ".Squash"},   {63'd0, squash}, {63'd0, sq});
    check({tag, ".IRQAck"},   {63'd0, irq_ack}, {63'd0, ack});
    check({tag, ".ExtIRQ"},   {63'd0, ext_irq}, {63'd0, ext});
    check({tag, ".Halted"},   {63'd0, halted}, {63'd0, hlt});
  endtask

  task automatic idle();
    irq_req = 1'b0; exc = 1'b0; eret = 1'b0; estatus = 4'd0;
  endtask

  initial begin
    // Hand-computed sequence; state carries from row to row.
    vt[0]  = mk(0,0,0,4'd0,64'h00,2'd0, 0,64'h00,0,0,0,0,64'h00);
    vt[1]  = mk(1,0,0,4'd0,64'h40,2'd0, 0,64'h00,0,0,0,0,64'h00);
    vt[2]  = mk(0,1,0,4'd1,64'h40,2'd0, 1,64'hD8,1,1,1,0,64'h00);
    vt[3]  = mk(0,0,0,4'd0,64'hD8,2'd0, 0,64'h00,0,0,0,0,64'h40);
    vt[4]  = mk(0,0,0,4'd0,64'hD8,2'd1, 0,64'h00,0,0,0,0,64'h01);
    vt[5]  = mk(0,0,0,4'd0,64'hD8,2'd2, 0,64'h00,0,0,0,0,64'h01);
    vt[6]  = mk(0,0,0,4'd0,64'hD8,2'd3, 0,64'h00,0,0,0,0,64'h00);
    vt[7]  = mk(0,0,1,4'd0,64'hDC,2'd0, 1,64'h40,0,0,0,0,64'h40);
    vt[8]  = mk(0,1,0,4'd2,64'h80,2'd1, 1,64'hD8,1,0,0,0,64'h01);
    vt[9]  = mk(1,0,0,4'd0,64'hD8,2'd2, 0,64'h00,0,0,0,0,64'h02);
    vt[10] = mk(1,0,1,4'd0,64'hDC,2'd1, 1,64'h80,0,0,0,0,64'h02);
    vt[11] = mk(1,1,0,4'd1,64'h84,2'd0, 1,64'hD8,1,1,1,0,64'h80);
    vt[12] = mk(0,0,0,4'd0,64'hD8,2'd0, 0,64'h00,0,0,0,0,64'h84);
    vt[13] = mk(1,1,0,4'd2,64'hDC,2'd2, 0,64'h00,1,0,0,0,64'h03);
    vt[14] = mk(1,1,1,4'd0,64'hE0,2'd2, 0,64'h00,1,0,0,1,64'h03);
    vt[15] = mk(0,0,0,4'd0,64'hE0,2'd0, 0,64'h00,1,0,0,1,64'h84);

    // Reset held from time 0 with an exception pending on the inputs.
    exc = 1'b1; estatus = 4'd1; irq_req = 1'b1;
    #2;
    check_outs("rst0", 0, 64'd0, 0, 0, 0, 0);
    for (int s = 0; s < 4; s++) begin
      sel = s[1:0];
      #1 check($sformatf("rst0.sys%0d", s), sys_data, 64'd0);
    end
    idle();
    sel = 2'd0;
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 16; i++) begin
      irq_req = vt[i].irq; exc = vt[i].exc; eret = vt[i].eret;
      estatus = vt[i].es; pc = vt[i].pc; sel = vt[i].sel;
      #2;
      check_outs($sformatf("row%0d", i), vt[i].e_red, vt[i].e_pc, vt[i].e_sq,
                 vt[i].e_ack, vt[i].e_ext, vt[i].e_halt);
      check($sformatf("row%0d.SysRegData", i), sys_data, vt[i].e_sys);
      @(negedge clk);
    end

    // Reset out of HALT; the first edge after release must capture IRQReq.
    #2;
    exc = 1'b1; eret = 1'b1; irq_req = 1'b1; estatus = 4'd1;
    #1 reset = 1'b0;
    #1 check_outs("haltrst", 0, 64'd0, 0, 0, 0, 0);
    @(negedge clk);
    idle();
    irq_req = 1'b1;
    reset = 1'b1;
    #2 check("rel.ExtIRQ_before", {63'd0, ext_irq}, 64'd0);
    @(negedge clk);
    irq_req = 1'b0;
    #2 check("rel.ExtIRQ_after", {63'd0, ext_irq}, 64'd1);
    exc = 1'b1; estatus = 4'd1; pc = 64'h100;
    #1 check("rel.IRQAck", {63'd0, irq_ack}, 64'd1);
    @(negedge clk);
    idle();

    // Mid-cycle reset inside the handler discards the return context.
    #1 reset = 1'b0;
    exc = 1'b1; eret = 1'b1;
    #1 check_outs("hdlrst", 0, 64'd0, 0, 0, 0, 0);
    for (int s = 0; s < 4; s++) begin
      sel = s[1:0];
      #1 check($sformatf("hdlrst.sys%0d", s), sys_data, 64'd0);
    end
    @(negedge clk);
    idle();
    sel = 2'd0;
    reset = 1'b1;
    #2 check_outs("post_rst", 0, 64'd0, 0, 0, 0, 0);
    check("post_rst.ELR", sys_data, 64'd0);
    exc = 1'b1; estatus = 4'd2; pc = 64'h200;
    #1 check_outs("post_rst.exc", 1, 64'hD8, 1, 0, 0, 0);
    @(negedge clk);
    idle();
    eret = 1'b1;
    #1 check("post_rst.ret", exc_pc, 64'h200);
    @(negedge clk);
    idle();

    // Counter saturation.
    force dut.u_regs.ecnt_q = 16'hFFFE;
    #1 release dut.u_regs.ecnt_q;
    sel = 2'd2;
    #1 check("ecnt.preset", sys_data, 64'hFFFE);
    exc = 1'b1; estatus = 4'd2; pc = 64'h300;
    @(negedge clk);
    idle();
    #1 check("ecnt.sat1", sys_data, 64'hFFFF);
    eret = 1'b1;
    @(negedge clk);
    idle();
    exc = 1'b1; estatus = 4'd2; pc = 64'h304;
    @(negedge clk);
    idle();
    #1 check("ecnt.sat2", sys_data, 64'hFFFF);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
